sensor_responder: RTL and testbench

SENSOR_RESPONDER -- requirements
Module: sensor_responder

---
 rtl/sensor_responder.sv | 132 +++++++++++++
 tb/tb_sensor_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_responder.sv
// sensor_responder: on request, acquires averaged ADC samples and counts pulse
// rising edges over a fixed window. It then holds one response record until the
// requester accepts it.
//
// Handshake: rsp_valid rises when the window closes and stays high until an edge
// samples rsp_valid=1 and rsp_ready=1. temp/pulses/error do not change while
// rsp_valid=1, and they keep their values after the handshake until the next
// window closes. rsp_ready has no effect outside RESPOND.
module sensor_responder #(
   parameter int AVG_SAMPLES   = 4,
   parameter int WINDOW_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sensor_request,
   input  logic [11:0] adc_inp,
   input  logic        adc_valid,
   input  logic        pulse,
   input  logic        rsp_ready,
   output logic        rsp_valid,
   output logic [7:0]  temp,
   output logic [7:0]  pulses,
   output logic        error,
   output logic        busy,
   output logic [1:0]  fsm_state
);

   localparam int SH = $clog2(AVG_SAMPLES);
   localparam int AW = 12 + SH;
   localparam int CW = SH + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(AVG_SAMPLES);
   localparam logic [15:0]   LAST_WIN = 16'(WINDOW_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t          state;
   logic [AW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic [15:0]     win;
   logic [7:0]      pcnt;
   logic            pulse_prev;

   logic [AW-1:0]   acc_next;
   logic [CW-1:0]   cnt_next;
   logic [7:0]      pcnt_next;

   assign fsm_state = state;

   // Values the accumulators take this edge, so that events on the last window
   // cycle are already included when the response is latched.
   always_comb begin
      acc_next  = acc;
      cnt_next  = cnt;
      pcnt_next = pcnt;
      if (adc_valid && (cnt < FULL_CNT)) begin
         acc_next = acc + AW'(adc_inp);
         cnt_next = cnt + CW'(1);
      end
      if (pulse && !pulse_prev && (pcnt != 8'hFF)) begin
         pcnt_next = pcnt + 8'd1;
      end
   end

   // Control FSM with registered outputs and acquisition counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         rsp_valid  <= 1'b0;
         busy       <= 1'b0;
         error      <= 1'b0;
         temp       <= 8'h00;
         pulses     <= 8'h00;
         acc        <= '0;
         cnt        <= '0;
         win        <= '0;
         pcnt       <= '0;
         pulse_prev <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sensor_request) begin
                  state      <= ACQUIRE;
                  busy       <= 1'b1;
                  acc        <= '0;
                  cnt        <= '0;
                  win        <= '0;
                  pcnt       <= '0;
                  pulse_prev <= pulse;
               end
            end
            ACQUIRE: begin
               acc        <= acc_next;
               cnt        <= cnt_next;
               pcnt       <= pcnt_next;
               pulse_prev <= pulse;
               if (win == LAST_WIN) begin
                  state     <= RESPOND;
                  rsp_valid <= 1'b1;
                  pulses    <= pcnt_next;
                  if (cnt_next == FULL_CNT) begin
                     // Mean of the samples, then keep the top 8 of its 12 bits.
                     temp  <= acc_next[SH+11:SH+4];
                     error <= 1'b0;
                  end else begin
                     temp  <= 8'h00;
                     error <= 1'b1;
                  end
               end else begin
                  win <= win + 16'd1;
               end
            end
            RESPOND: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_responder.sv
// Bench for sensor_responder. The main instance uses a 16-cycle window. A second
// instance with a 1024-cycle window covers pulse-count saturation. Expected
// records come from a window-level model: the mean of the first AVG_SAMPLES
// strobes and a count of rising edges.
module tb_sensor_responder;

   localparam int N  = 4;
   localparam int W1 = 16;
   localparam int W2 = 1024;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        sensor_request = 1'b0;
   logic [11:0] adc_inp = 12'h000;
   logic        adc_valid = 1'b0;
   logic        pulse = 1'b0;
   logic        rsp_ready = 1'b0;
   logic        req2 = 1'b0;
   logic        rdy2 = 1'b0;

   logic        rsp_valid, error, busy;
   logic [7:0]  temp, pulses;
   logic [1:0]  fsm_state;
   logic        rsp_valid2, error2, busy2;
   logic [7:0]  temp2, pulses2;
   logic [1:0]  fsm_state2;

   int checks = 0;
   int errors = 0;

   // Stimulus for one window: index i is applied at the i-th ACQUIRE edge.
   bit          v_a [W2];
   logic [11:0] d_a [W2];
   bit          p_a [W2];
   bit          p0_g;

   // Expected {temp, pulses, error} records, oldest first.
   logic [16:0] exp_q[$];

   sensor_responder #(.AVG_SAMPLES(N), .WINDOW_CYCLES(W1)) dut (
      .clock(clock), .reset(reset), .sensor_request(sensor_request),
      .adc_inp(adc_inp), .adc_valid(adc_valid), .pulse(pulse),
      .rsp_ready(rsp_ready), .rsp_valid(rsp_valid), .temp(temp),
      .pulses(pulses), .error(error), .busy(busy), .fsm_state(fsm_state)
   );

   sensor_responder #(.AVG_SAMPLES(N), .WINDOW_CYCLES(W2)) dut2 (
      .clock(clock), .reset(reset), .sensor_request(req2),
      .adc_inp(adc_inp), .adc_valid(adc_valid), .pulse(pulse),
      .rsp_ready(rdy2), .rsp_valid(rsp_valid2), .temp(temp2),
      .pulses(pulses2), .error(error2), .busy(busy2), .fsm_state(fsm_state2)
   );

   // Clock and reset-free clock generation.
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_req(input bit use2, input logic v);
      if (use2) req2 = v;
      else sensor_request = v;
   endtask

   task automatic drive_rdy(input bit use2, input logic v);
      if (use2) rdy2 = v;
      else rsp_ready = v;
   endtask

   // {rsp_valid, busy, temp, pulses, error} of the selected instance.
   function automatic logic [18:0] obs(input bit use2);
      if (use2) return {rsp_valid2, busy2, temp2, pulses2, error2};
      return {rsp_valid, busy, temp, pulses, error};
   endfunction

   task automatic clear_stim();
      for (int i = 0; i < W2; i++) begin
         v_a[i] = 1'b0;
         d_a[i] = 12'h000;
         p_a[i] = 1'b0;
      end
      p0_g = 1'b0;
   endtask

   // Window-level reference: mean of the first N strobes, rising edges relative
   // to the level seen at the request edge, saturating at 255.
   task automatic model(input int w);
      int sum;
      int n;
      int edges;
      bit prev;
      logic [7:0] t;
      logic [7:0] pc;
      logic e;
      sum = 0;
      n = 0;
      edges = 0;
      prev = p0_g;
      for (int i = 0; i < w; i++) begin
         if (v_a[i] && n < N) begin
            sum += int'(d_a[i]);
            n++;
         end
         if (p_a[i] && !prev) edges++;
         prev = p_a[i];
      end
      pc = (edges > 255) ? 8'd255 : 8'(edges);
      if (n == N) begin
         t = 8'(((sum / N) >> 4) & 255);
         e = 1'b0;
      end else begin
         t = 8'h00;
         e = 1'b1;
      end
      exp_q.push_back({t, pc, e});
   endtask

   // One full transaction: request, window, response held for 'hold' cycles,
   // then handshake. With b2b set, the request stays high through the handshake.
   task automatic run_window(input int w, input bit use2, input int hold, input bit b2b);
      logic [16:0] exp;
      logic [18:0] o;
      model(w);
      drive_req(use2, 1'b1);
      pulse = p0_g;
      adc_valid = 1'b0;
      step();
      o = obs(use2);
      checks++;
      if (o[17] !== 1'b1 || o[18] !== 1'b0) begin
         errors++;
         $display("FAIL start_busy: busy=%b rsp_valid=%b required busy=1 rsp_valid=0", o[17], o[18]);
      end
      for (int i = 0; i < w; i++) begin
         adc_valid = v_a[i];
         adc_inp = v_a[i] ? d_a[i] : 12'($urandom);
         pulse = p_a[i];
         drive_rdy(use2, 1'($urandom_range(0, 1)));
         drive_req(use2, 1'($urandom_range(0, 1)));
         o = obs(use2);
         checks++;
         if (o[18] !== 1'b0 || o[17] !== 1'b1) begin
            errors++;
            $display("FAIL acquire_cycle %0d: rsp_valid=%b busy=%b required 0/1", i, o[18], o[17]);
         end
         step();
      end
      adc_valid = 1'b0;
      exp = exp_q.pop_front();
      for (int h = 0; h <= hold; h++) begin
         drive_rdy(use2, 1'b0);
         drive_req(use2, 1'($urandom_range(0, 1)));
         o = obs(use2);
         checks++;
         if (o[18] !== 1'b1 || o[17] !== 1'b1 || o[16:0] !== exp) begin
            errors++;
            $display("FAIL respond_hold %0d: valid=%b busy=%b rec=%h required 1/1 rec=%h", h, o[18], o[17], o[16:0], exp);
         end
         if (h < hold) step();
      end
      drive_rdy(use2, 1'b1);
      drive_req(use2, b2b);
      step();
      drive_rdy(use2, 1'b0);
      o = obs(use2);
      checks++;
      if (o[18] !== 1'b0 || o[17] !== 1'b0 || o[16:0] !== exp) begin
         errors++;
         $display("FAIL handshake: valid=%b busy=%b rec=%h required 0/0 rec=%h", o[18], o[17], o[16:0], exp);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({rsp_valid, busy, temp, pulses, error} !== 19'h0) begin
         errors++;
         $display("FAIL reset_async: got %h required 0", {rsp_valid, busy, temp, pulses, error});
      end
      sensor_request = 1'b1;
      step();
      step();
      checks++;
      if ({rsp_valid, busy, temp, pulses, error, rsp_valid2, busy2} !== 21'h0) begin
         errors++;
         $display("FAIL reset_held: got %h required 0", {rsp_valid, busy, temp, pulses, error, rsp_valid2, busy2});
      end
      sensor_request = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_request: busy=%b required 0", busy);
      end
   endtask

   task automatic test_average();
      clear_stim();
      v_a[1] = 1; d_a[1] = 12'h100;
      v_a[3] = 1; d_a[3] = 12'h200;
      v_a[5] = 1; d_a[5] = 12'h300;
      v_a[7] = 1; d_a[7] = 12'h400;
      run_window(W1, 1'b0, 1, 1'b0);
      checks++;
      if (temp !== 8'h28 || error !== 1'b0) begin
         errors++;
         $display("FAIL average_known: temp=%h error=%b required 28/0", temp, error);
      end
   endtask

   task automatic test_pulse_edges();
      clear_stim();
      p0_g = 1'b1;
      for (int i = 1; i <= 4; i++) p_a[i] = 1'b1;
      p_a[6] = 1'b1;
      p_a[15] = 1'b1;
      for (int i = 0; i < N; i++) begin
         v_a[2 * i] = 1'b1;
         d_a[2 * i] = 12'(16'h0800 + i * 16'h10);
      end
      run_window(W1, 1'b0, 0, 1'b0);
      checks++;
      if (pulses !== 8'd3) begin
         errors++;
         $display("FAIL pulse_edges: pulses=%0d required 3", pulses);
      end
   endtask

   task automatic test_short_samples();
      clear_stim();
      v_a[2] = 1; d_a[2] = 12'hFFF;
      v_a[9] = 1; d_a[9] = 12'hABC;
      p_a[4] = 1'b1;
      run_window(W1, 1'b0, 0, 1'b0);
      checks++;
      if (temp !== 8'h00 || error !== 1'b1 || pulses !== 8'd1) begin
         errors++;
         $display("FAIL short_samples: temp=%h error=%b pulses=%0d required 00/1/1", temp, error, pulses);
      end
   endtask

   task automatic test_sample_boundaries();
      // Fourth sample on the last window cycle still counts.
      clear_stim();
      v_a[0] = 1; d_a[0] = 12'h111;
      v_a[5] = 1; d_a[5] = 12'h222;
      v_a[9] = 1; d_a[9] = 12'h333;
      v_a[15] = 1; d_a[15] = 12'hFFF;
      run_window(W1, 1'b0, 2, 1'b0);
      // Samples beyond the fourth are discarded.
      clear_stim();
      for (int i = 0; i < 6; i++) begin
         v_a[i] = 1'b1;
         d_a[i] = (i < N) ? 12'h040 : 12'hFFF;
      end
      run_window(W1, 1'b0, 0, 1'b0);
      checks++;
      if (temp !== 8'h04) begin
         errors++;
         $display("FAIL discard_extra: temp=%h required 04", temp);
      end
   endtask

   task automatic test_hold_ready();
      clear_stim();
      for (int i = 0; i < N; i++) begin
         v_a[3 * i] = 1'b1;
         d_a[3 * i] = 12'($urandom);
      end
      p_a[10] = 1'b1;
      run_window(W1, 1'b0, 5, 1'b0);
      step();
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL after_handshake_idle: busy=%b rsp_valid=%b required 0/0", busy, rsp_valid);
      end
   endtask

   task automatic test_reset_mid_acquire();
      clear_stim();
      sensor_request = 1'b1;
      step();
      sensor_request = 1'b0;
      for (int i = 0; i < 8; i++) step();
      checks++;
      if (busy !== 1'b1 || temp === 8'h00) begin
         errors++;
         $display("FAIL pre_reset_state: busy=%b temp=%h required busy=1 temp!=0", busy, temp);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, busy, temp, pulses, error} !== 19'h0) begin
         errors++;
         $display("FAIL reset_mid_acquire: got %h required 0", {rsp_valid, busy, temp, pulses, error});
      end
      @(negedge clock);
      reset = 1'b1;
      step();
      v_a[15] = 1; d_a[15] = 12'h7F0;
      p_a[12] = 1'b1;
      run_window(W1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         clear_stim();
         for (int i = 0; i < W1; i++) begin
            v_a[i] = 1'($urandom_range(0, 1));
            d_a[i] = 12'($urandom);
            p_a[i] = 1'($urandom_range(0, 1));
         end
         run_window(W1, 1'b0, k, 1'b1);
      end
      sensor_request = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         clear_stim();
         p0_g = 1'($urandom_range(0, 1));
         for (int i = 0; i < W1; i++) begin
            v_a[i] = ($urandom_range(0, 2) == 0);
            d_a[i] = 12'($urandom);
            p_a[i] = 1'($urandom_range(0, 1));
         end
         run_window(W1, 1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      sensor_request = 1'b0;
      step();
   endtask

   task automatic test_saturation();
      clear_stim();
      for (int i = 0; i < W2; i++) p_a[i] = 1'(i % 2);
      for (int i = 0; i < N; i++) begin
         v_a[100 + 200 * i] = 1'b1;
         d_a[100 + 200 * i] = 12'($urandom);
      end
      run_window(W2, 1'b1, 1, 1'b0);
      checks++;
      if (pulses2 !== 8'd255 || error2 !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL saturation: pulses=%0d error=%b main_busy=%b required 255/0/0", pulses2, error2, busy);
      end
   endtask

   initial begin
      test_reset();
      test_average();
      test_pulse_edges();
      test_short_samples();
      test_sample_boundaries();
      test_hold_ready();
      test_reset_mid_acquire();
      test_back_to_back();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
